// File: rtl/button_led_ctrl.sv
// N-channel button-to-LED controller: sync, debounce, press pulse,
// and a per-channel OFF/ON/BLINK/DIM mode cycle driving active-low LEDs.
module button_led_ctrl #(
   parameter int NUM_CH          = 3,
   parameter int DEBOUNCE_CYCLES = 12000,
   parameter int PWM_BITS        = 8,
   parameter int DIM_LEVEL       = 32,
   parameter int BLINK_CYCLES    = 6000000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_CH-1:0]   button_i,
   output logic [NUM_CH-1:0]   led_o,
   output logic [NUM_CH-1:0]   pressed_o,
   output logic [2*NUM_CH-1:0] mode_o
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
   localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [BW-1:0] BL_MAX = BW'(BLINK_CYCLES - 1);

   typedef enum logic [1:0] {
      M_OFF   = 2'd0,
      M_ON    = 2'd1,
      M_BLINK = 2'd2,
      M_DIM   = 2'd3
   } mode_t;

   logic [PWM_BITS-1:0] pwm_cnt;
   logic [BW-1:0]       blink_cnt;
   logic                blink_ph;
   logic                dim_on;

   // Shared free-running PWM counter and blink half-period timebase
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pwm_cnt   <= '0;
         blink_cnt <= '0;
         blink_ph  <= 1'b0;
      end else begin
         pwm_cnt <= pwm_cnt + 1'b1;
         if (blink_cnt == BL_MAX) begin
            blink_cnt <= '0;
            blink_ph  <= ~blink_ph;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
      end
   end

   // DIM duty compare done once; zero-extend so large levels saturate to lit
   assign dim_on = (int'(pwm_cnt) < DIM_LEVEL);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [1:0]    sync;
      logic          stable;
      logic [CW-1:0] cnt;
      logic          press_q;
      mode_t         mode_q;
      logic          lit;
      logic          led_q;

      // Two-flop synchroniser, idles at released (1)
      always_ff @(posedge clk or posedge reset) begin
         if (reset) sync <= 2'b11;
         else       sync <= {sync[0], button_i[i]};
      end

      // Debounce; pulse registered on the same edge stable falls
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            stable  <= 1'b1;
            cnt     <= '0;
            press_q <= 1'b0;
         end else begin
            press_q <= 1'b0;
            if (sync[1] == stable) begin
               cnt <= '0;
            end else if (cnt == DB_MAX) begin
               stable  <= sync[1];
               cnt     <= '0;
               press_q <= stable;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end

      // Mode FSM steps once per press pulse
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            mode_q <= M_OFF;
         end else if (press_q) begin
            unique case (mode_q)
               M_OFF:   mode_q <= M_ON;
               M_ON:    mode_q <= M_BLINK;
               M_BLINK: mode_q <= M_DIM;
               M_DIM:   mode_q <= M_OFF;
            endcase
         end
      end

      // Lit condition for the current mode
      always_comb begin
         lit = 1'b0;
         unique case (mode_q)
            M_OFF:   lit = 1'b0;
            M_ON:    lit = 1'b1;
            M_BLINK: lit = blink_ph;
            M_DIM:   lit = dim_on;
         endcase
      end

      // Registered active-low LED drive
      always_ff @(posedge clk or posedge reset) begin
         if (reset) led_q <= 1'b1;
         else       led_q <= ~lit;
      end

      assign led_o[i]          = led_q;
      assign pressed_o[i]      = press_q;
      assign mode_o[2*i +: 2]  = mode_q;
   end

endmodule

// File: tb/tb_button_led_ctrl.sv
// Directed bench for button_led_ctrl with small debounce/blink/PWM settings.
`timescale 1ns/1ps
module tb_button_led_ctrl;

   logic       clk;
   logic       reset;
   logic [2:0] button_i;
   logic [2:0] led_o;
   logic [2:0] pressed_o;
   logic [5:0] mode_o;

   int n_cmp;
   int n_fail;

   button_led_ctrl #(
      .NUM_CH(3),
      .DEBOUNCE_CYCLES(4),
      .PWM_BITS(4),
      .DIM_LEVEL(4),
      .BLINK_CYCLES(8)
   ) dut (
      .clk(clk),
      .reset(reset),
      .button_i(button_i),
      .led_o(led_o),
      .pressed_o(pressed_o),
      .mode_o(mode_o)
   );

   initial clk = 1'b0;
   always #42 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Hold mask low for 6 edges (sync + debounce), check pulse, release
   task automatic press(input logic [2:0] m);
      button_i = ~m;
      repeat (6) tick();
      check("press_pulse", {29'd0, pressed_o}, {29'd0, m});
      button_i = 3'b111;
      repeat (8) tick();
   endtask

   initial begin
      logic b0;
      logic found;
      int   lows;
      n_cmp    = 0;
      n_fail   = 0;
      reset    = 1'b1;
      button_i = 3'b111;

      // reset state
      repeat (3) tick();
      check("rst_led", {29'd0, led_o}, 32'h7);
      check("rst_mode", {26'd0, mode_o}, 32'h0);
      check("rst_pressed", {29'd0, pressed_o}, 32'h0);
      reset = 1'b0;

      // idle buttons
      for (int j = 0; j < 100; j++) begin
         tick();
         check("idle_pressed", {29'd0, pressed_o}, 32'h0);
      end
      check("idle_led", {29'd0, led_o}, 32'h7);
      check("idle_mode", {26'd0, mode_o}, 32'h0);

      // channel 0 press and hold
      button_i = 3'b110;
      for (int j = 1; j <= 5; j++) begin
         tick();
         check("ch0_early", {29'd0, pressed_o}, 32'h0);
      end
      tick();
      check("ch0_edge6", {29'd0, pressed_o}, 32'h1);
      tick();
      check("ch0_pulse_end", {29'd0, pressed_o}, 32'h0);
      check("ch0_mode", {26'd0, mode_o}, 32'h01);
      tick();
      check("ch0_led", {29'd0, led_o}, 32'h6);
      for (int j = 0; j < 20; j++) begin
         tick();
         check("ch0_hold", {29'd0, pressed_o}, 32'h0);
      end
      button_i = 3'b111;
      repeat (10) tick();

      // channel 1 glitch of 3 cycles
      button_i = 3'b101;
      repeat (3) tick();
      button_i = 3'b111;
      for (int j = 0; j < 10; j++) begin
         tick();
         check("glitch_pressed", {29'd0, pressed_o}, 32'h0);
      end
      check("glitch_mode", {26'd0, mode_o}, 32'h01);

      // channel 1 low for exactly 4 cycles
      button_i = 3'b101;
      for (int j = 1; j <= 5; j++) begin
         tick();
         if (j == 4) button_i = 3'b111;
         check("ch1_early", {29'd0, pressed_o}, 32'h0);
      end
      tick();
      check("ch1_pulse", {29'd0, pressed_o}, 32'h2);
      tick();
      check("ch1_mode", {26'd0, mode_o}, 32'h05);
      for (int j = 0; j < 10; j++) begin
         tick();
         check("ch1_release", {29'd0, pressed_o}, 32'h0);
      end

      // channel 2: ON then BLINK
      press(3'b100);
      press(3'b100);
      check("ch2_blink_mode", {26'd0, mode_o}, 32'h25);
      b0 = led_o[2];
      found = 1'b0;
      for (int j = 0; j < 20 && !found; j++) begin
         tick();
         if (led_o[2] !== b0) found = 1'b1;
      end
      check("blink_edge", {31'd0, found}, 32'h1);
      b0 = led_o[2];
      for (int h = 0; h < 2; h++) begin
         for (int j = 1; j <= 7; j++) begin
            tick();
            check("blink_hold", {31'd0, led_o[2]}, {31'd0, b0});
         end
         tick();
         check("blink_toggle", {31'd0, led_o[2]}, {31'd0, ~b0});
         b0 = ~b0;
      end

      // channel 2: DIM, 4 lit cycles per 16
      press(3'b100);
      check("ch2_dim_mode", {26'd0, mode_o}, 32'h35);
      lows = 0;
      for (int j = 0; j < 32; j++) begin
         tick();
         if (led_o[2] == 1'b0) lows++;
      end
      check("dim_duty", lows, 32'd8);

      // channel 2: back to OFF
      press(3'b100);
      check("ch2_off_mode", {26'd0, mode_o}, 32'h05);
      for (int j = 0; j < 16; j++) begin
         tick();
         check("ch2_off_led", {31'd0, led_o[2]}, 32'h1);
      end

      // simultaneous press on all channels
      press(3'b111);
      check("all_mode", {26'd0, mode_o}, 32'h1A);

      // reset mid-debounce with channel 0 held
      button_i = 3'b110;
      repeat (4) tick();
      reset = 1'b1;
      #1;
      check("async_rst_mode", {26'd0, mode_o}, 32'h0);
      check("async_rst_led", {29'd0, led_o}, 32'h7);
      check("async_rst_pressed", {29'd0, pressed_o}, 32'h0);
      repeat (2) tick();
      reset = 1'b0;
      for (int j = 1; j <= 5; j++) begin
         tick();
         check("post_rst_early", {29'd0, pressed_o}, 32'h0);
      end
      tick();
      check("post_rst_pulse", {29'd0, pressed_o}, 32'h1);
      tick();
      check("post_rst_mode", {26'd0, mode_o}, 32'h01);
      tick();
      check("post_rst_led", {29'd0, led_o}, 32'h6);
      for (int j = 0; j < 20; j++) begin
         tick();
         check("post_rst_hold", {29'd0, pressed_o}, 32'h0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
